rs_issue_select: RTL

- Reservation-station storage and issue stage for the add-class unit: add/sub (0000/0001), load/store (0100/0101), branch (0110/0111).
- Sits downstream of the dispatch/append logic, which writes one entry per cycle.
- Holds entries until both source operands are captured, snooping the common data bus (CDB) for tags.
- Issues the oldest ready entry to the add-class functional unit through a registered valid/ready output.

---
 rtl/rs_issue_select.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/rs_issue_select.sv
// Reservation station for the add-class unit: holds dispatched ops until both
// operands are captured from the CDB, then issues the oldest ready one through a registered output.
module rs_issue_select #(
    parameter int DEPTH = 4,
    parameter int DW    = 16,
    parameter int TAGW  = 3,
    parameter int FW    = 4
) (
    input  logic                       clk2,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       alloc_valid,
    output logic                       alloc_ready,
    input  logic [FW-1:0]              alloc_func,
    input  logic [TAGW-1:0]            alloc_rob,
    input  logic                       alloc_rdy1,
    input  logic [DW-1:0]              alloc_v1,
    input  logic [TAGW-1:0]            alloc_q1,
    input  logic                       alloc_rdy2,
    input  logic [DW-1:0]              alloc_v2,
    input  logic [TAGW-1:0]            alloc_q2,
    input  logic                       cdb_valid,
    input  logic [TAGW-1:0]            cdb_tag,
    input  logic [DW-1:0]              cdb_data,
    output logic                       iss_valid,
    input  logic                       iss_ready,
    output logic [FW-1:0]              iss_func,
    output logic [DW-1:0]              iss_a,
    output logic [DW-1:0]              iss_b,
    output logic [TAGW-1:0]            iss_rob,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] rdy1;
    logic [DEPTH-1:0] rdy2;
    logic [FW-1:0]    e_func [DEPTH];
    logic [TAGW-1:0]  e_rob  [DEPTH];
    logic [DW-1:0]    e_v1   [DEPTH];
    logic [DW-1:0]    e_v2   [DEPTH];
    logic [TAGW-1:0]  e_q1   [DEPTH];
    logic [TAGW-1:0]  e_q2   [DEPTH];
    logic [AW-1:0]    e_age  [DEPTH];
    logic [AW:0]      cnt;

    logic [DEPTH-1:0] alloc_oh;
    logic [DEPTH-1:0] sel_oh;
    logic             alloc_fire;
    logic             issue_fire;
    logic             any_ready;
    logic             free_found;
    logic [AW-1:0]    sel_age;
    logic [AW-1:0]    alloc_age;
    logic [FW-1:0]    sel_func;
    logic [DW-1:0]    sel_a;
    logic [DW-1:0]    sel_b;
    logic [TAGW-1:0]  sel_rob;
    logic             byp1;
    logic             byp2;

    assign alloc_ready = !(&busy);
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign issue_fire  = (!iss_valid || iss_ready) && any_ready;
    assign occupancy   = cnt;
    assign byp1        = cdb_valid && !alloc_rdy1 && (cdb_tag == alloc_q1);
    assign byp2        = cdb_valid && !alloc_rdy2 && (cdb_tag == alloc_q2);
    // The new entry is younger than anything issuing, so it shares the same age decrement.
    assign alloc_age   = cnt[AW-1:0] - AW'(issue_fire);

    always_comb begin
        alloc_oh   = '0;
        free_found = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!busy[i] && !free_found) begin
                alloc_oh[i] = alloc_fire;
                free_found  = 1'b1;
            end
        end
    end

    // Strict compare keeps the lowest index on an (unexpected) age tie.
    always_comb begin
        sel_oh    = '0;
        any_ready = 1'b0;
        sel_age   = '0;
        sel_func  = '0;
        sel_a     = '0;
        sel_b     = '0;
        sel_rob   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (busy[i] && rdy1[i] && rdy2[i] && (!any_ready || e_age[i] < sel_age)) begin
                any_ready = 1'b1;
                sel_age   = e_age[i];
                sel_oh    = '0;
                sel_oh[i] = 1'b1;
                sel_func  = e_func[i];
                sel_a     = e_v1[i];
                sel_b     = e_v2[i];
                sel_rob   = e_rob[i];
            end
        end
    end

    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            busy <= '0;
            rdy1 <= '0;
            rdy2 <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                e_func[i] <= '0;
                e_rob[i]  <= '0;
                e_v1[i]   <= '0;
                e_v2[i]   <= '0;
                e_q1[i]   <= '0;
                e_q2[i]   <= '0;
                e_age[i]  <= '0;
            end
            cnt       <= '0;
            iss_valid <= 1'b0;
            iss_func  <= '0;
            iss_a     <= '0;
            iss_b     <= '0;
            iss_rob   <= '0;
        end else if (flush) begin
            busy      <= '0;
            cnt       <= '0;
            iss_valid <= 1'b0;
            iss_func  <= '0;
            iss_a     <= '0;
            iss_b     <= '0;
            iss_rob   <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (alloc_oh[i]) begin
                    busy[i]   <= 1'b1;
                    e_func[i] <= alloc_func;
                    e_rob[i]  <= alloc_rob;
                    e_q1[i]   <= alloc_q1;
                    e_q2[i]   <= alloc_q2;
                    rdy1[i]   <= alloc_rdy1 || byp1;
                    rdy2[i]   <= alloc_rdy2 || byp2;
                    e_v1[i]   <= byp1 ? cdb_data : alloc_v1;
                    e_v2[i]   <= byp2 ? cdb_data : alloc_v2;
                    e_age[i]  <= alloc_age;
                end else if (busy[i]) begin
                    if (issue_fire && sel_oh[i]) begin
                        busy[i] <= 1'b0;
                    end
                    if (cdb_valid && !rdy1[i] && (e_q1[i] == cdb_tag)) begin
                        rdy1[i] <= 1'b1;
                        e_v1[i] <= cdb_data;
                    end
                    if (cdb_valid && !rdy2[i] && (e_q2[i] == cdb_tag)) begin
                        rdy2[i] <= 1'b1;
                        e_v2[i] <= cdb_data;
                    end
                    if (issue_fire && (e_age[i] > sel_age)) begin
                        e_age[i] <= e_age[i] - 1'b1;
                    end
                end
            end
            cnt <= cnt + (AW+1)'(alloc_fire) - (AW+1)'(issue_fire);
            if (issue_fire) begin
                iss_valid <= 1'b1;
                iss_func  <= sel_func;
                iss_a     <= sel_a;
                iss_b     <= sel_b;
                iss_rob   <= sel_rob;
            end else if (iss_ready) begin
                iss_valid <= 1'b0;
            end
        end
    end

endmodule
